srff_activity_sequencer: RTL

Programmable stimulus sequencer for one SR flip-flop instance under power characterisation. It plays a stored list of {sr code, hold length} steps onto the flip-flop's sr input and counts q transitions and illegal (2'b11) codes during the run. The counts are the switching-activity figures the estimator consumes, replacing hand-written delay-based stimulus.

---
 rtl/srff_pkg.sv | 27 ++
 rtl/srff_activity_sequencer_if.sv | 34 +++
 rtl/sat_counter.sv | 26 ++
 rtl/srff_activity_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/srff_pkg.sv
// Shared types and constants for the SR flip-flop activity sequencer.
package srff_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // sr codes: bit1 = S, bit0 = R
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

  localparam int unsigned ENTRY_HOLD_W = 4;

  typedef struct packed {
    logic [1:0]              sr;
    logic [ENTRY_HOLD_W-1:0] hold;
  } entry_t;

  function automatic logic is_illegal(logic [1:0] code);
    return code == SR_ILL;
  endfunction

endpackage

// File: rtl/srff_activity_sequencer_if.sv
// Configuration, control and activity-count signals of the sequencer.
interface srff_activity_sequencer_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned TOG_W  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) ();

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [1:0]        cfg_sr;
  logic [HOLD_W-1:0] cfg_hold;
  logic [AW:0]       cfg_len;
  logic              start;
  logic              abort;
  logic              q_in;
  logic [1:0]        sr_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;
  logic [TOG_W-1:0]  toggle_count;
  logic [TOG_W-1:0]  illegal_count;

  modport master (
    output cfg_we, cfg_addr, cfg_sr, cfg_hold, cfg_len, start, abort, q_in,
    input  sr_out, busy, done, step_idx, toggle_count, illegal_count
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sr, cfg_hold, cfg_len, start, abort, q_in,
    output sr_out, busy, done, step_idx, toggle_count, illegal_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/srff_activity_sequencer.sv
// Plays a stored {sr, hold} program onto an SR flip-flop and counts q toggles
// and illegal-code steps as switching-activity figures.
module srff_activity_sequencer
  import srff_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned TOG_W  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input logic                      clk,
  input logic                      rst_n,
  srff_activity_sequencer_if.slave bus
);

  typedef struct packed {
    logic [1:0]        sr;
    logic [HOLD_W-1:0] hold;
  } step_t;

  step_t mem [DEPTH];

  state_e            state_q;
  logic [1:0]        sr_q;
  logic              busy_q;
  logic              done_q;
  logic [AW-1:0]     idx_q;
  logic [HOLD_W-1:0] hold_q;
  logic [AW:0]       len_q;
  logic              first_q;
  logic              q_hist_q;

  logic          go;
  logic          last_step;
  logic          toggle_inc;
  logic          illegal_inc;
  logic [AW-1:0] idx_nxt;
  step_t         next_step;

  always_comb begin
    go          = (state_q == StIdle) && bus.start && !bus.abort;
    idx_nxt     = idx_q + AW'(1);
    next_step   = mem[idx_nxt];
    last_step   = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));
    toggle_inc  = ((state_q == StRun) || (state_q == StDone)) && (bus.q_in != q_hist_q);
    // first_q marks the opening cycle of a step, so each step is counted once
    illegal_inc = (state_q == StRun) && first_q && is_illegal(sr_q);
  end

  // Program memory is deliberately not reset; writes are locked out while running.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q != StRun)) begin
      mem[bus.cfg_addr] <= '{sr: bus.cfg_sr, hold: bus.cfg_hold};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_hist_q <= 1'b0;
    end else begin
      q_hist_q <= bus.q_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= SR_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
      len_q   <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            if (bus.cfg_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              len_q   <= bus.cfg_len;
              idx_q   <= '0;
              hold_q  <= mem[0].hold;
              sr_q    <= mem[0].sr;
              first_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            sr_q    <= SR_HOLD;
          end else if (hold_q == '0) begin
            if (last_step) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sr_q    <= SR_HOLD;
            end else begin
              idx_q   <= idx_nxt;
              hold_q  <= next_step.hold;
              sr_q    <= next_step.sr;
              first_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  sat_counter #(
    .Width(TOG_W)
  ) u_toggle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(go),
    .inc  (toggle_inc),
    .count(bus.toggle_count)
  );

  sat_counter #(
    .Width(TOG_W)
  ) u_illegal_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(go),
    .inc  (illegal_inc),
    .count(bus.illegal_count)
  );

  assign bus.sr_out   = sr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = idx_q;

endmodule
